pe_mac_bidir: RTL and testbench

- Next-generation systolic-array PE (multiply-accumulate processing element).
- Operand flow direction is selectable at run time: vertical N->S or S->N, horizontal W->E or E->W.
- Fixed-point format is parametrised, with saturating accumulation and a sticky overflow flag.
- A small result FIFO resolves collisions between the PE's own result and forwarded upstream results. Instantiated in a 2-D grid of the RSA array.

---
 rtl/pe_mac_bidir.sv | 125 ++++++++++++
 tb/tb_pe_mac_bidir.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_bidir.sv
// pe_mac_bidir: bidirectional systolic MAC PE with saturating accumulator and result collision FIFO
module pe_mac_bidir #(
  parameter int RSA_DW    = 16,
  parameter int FRAC_BIT  = 8,
  parameter int ACC_GUARD = 4,
  parameter int SAT_EN    = 1,
  parameter int RES_DEPTH = 2
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [1:0]        PE_mode,
  input  logic              dir_v,
  input  logic              dir_h,
  input  logic [1:0]        ctl_N_i,
  input  logic [1:0]        ctl_S_i,
  output logic [1:0]        ctl_N_o,
  output logic [1:0]        ctl_S_o,
  input  logic [RSA_DW-1:0] v_N_i,
  input  logic [RSA_DW-1:0] v_S_i,
  output logic [RSA_DW-1:0] v_N_o,
  output logic [RSA_DW-1:0] v_S_o,
  input  logic [RSA_DW-1:0] h_W_i,
  input  logic [RSA_DW-1:0] h_E_i,
  output logic [RSA_DW-1:0] h_W_o,
  output logic [RSA_DW-1:0] h_E_o,
  input  logic [RSA_DW:0]   res_W_i,
  input  logic [RSA_DW:0]   res_E_i,
  output logic [RSA_DW:0]   res_W_o,
  output logic [RSA_DW:0]   res_E_o,
  output logic              ovf_o,
  output logic              drop_o
);
  localparam int AW = RSA_DW + ACC_GUARD;
  localparam int PW = 2 * RSA_DW;
  localparam int SW = PW + 1;
  localparam int RW = RSA_DW + 1;
  localparam int FW = $clog2(RES_DEPTH);
  logic [1:0] ctl_in, ctl_N_q, ctl_N_d, ctl_S_q, ctl_S_d;
  logic cal_en, cal_done, cfg_chg, acc_upd, ovf_aw, ovf_dw;
  logic signed [RSA_DW-1:0] v_in, h_in;
  logic [RSA_DW-1:0] v_fwd, h_fwd, v_N_q, v_N_d, v_S_q, v_S_d, h_W_q, h_W_d, h_E_q, h_E_d, own;
  logic [3:0] cfg, cfg_q;
  logic signed [PW-1:0] prod_q, prod_d, sc;
  logic signed [SW-1:0] sum;
  logic signed [AW-1:0] acc_q, acc_d, sat_aw;
  logic ovf_q, ovf_d, done_q, done_d, drop_q, drop_d;
  logic [RW-1:0] res_in, head, own_w, sel, p0, res_W_q, res_W_d, res_E_q, res_E_d;
  logic head_v, own_v, in_v, p0_v, p1_v, ok0, ok1;
  logic [RW-1:0] mem_q [RES_DEPTH];
  logic [RW-1:0] mem_d [RES_DEPTH];
  logic [FW-1:0] wp_q, wp_d, wp1, rp_q, rp_d;
  logic [FW:0] cnt_q, cnt_d, free;
  assign {ctl_N_o, ctl_S_o, v_N_o, v_S_o} = {ctl_N_q, ctl_S_q, v_N_q, v_S_q};
  assign {h_W_o, h_E_o, res_W_o, res_E_o} = {h_W_q, h_E_q, res_W_q, res_E_q};
  assign {ovf_o, drop_o} = {ovf_q, drop_q};
  // Side selection, operand forwarding, multiply/accumulate and overflow tracking
  always_comb begin
    ctl_in = dir_v ? ctl_S_i : ctl_N_i;
    cal_en = ctl_in[0];
    cal_done = ctl_in[1];
    v_in = dir_v ? v_S_i : v_N_i;
    h_in = dir_h ? h_E_i : h_W_i;
    cfg = {PE_mode, dir_v, dir_h};
    cfg_chg = cfg != cfg_q;
    v_fwd = cal_en ? v_in : '0;
    h_fwd = cal_en ? h_in : '0;
    ctl_N_d = dir_v ? ctl_in : 2'b00;
    ctl_S_d = dir_v ? 2'b00 : ctl_in;
    v_N_d = dir_v ? v_fwd : '0;
    v_S_d = dir_v ? '0 : v_fwd;
    h_W_d = dir_h ? h_fwd : '0;
    h_E_d = dir_h ? '0 : h_fwd;
    prod_d = cal_en ? PW'(h_in) * PW'(v_in) : '0;
    sc = prod_q >>> FRAC_BIT;
    sum = SW'(sc) + SW'(acc_q);
    ovf_aw = sum[SW-1:AW-1] != {(SW-AW+1){sum[SW-1]}};
    sat_aw = ovf_aw ? {sum[SW-1], {(AW-1){~sum[SW-1]}}} : sum[AW-1:0];
    ovf_dw = (SAT_EN != 0) && (sat_aw[AW-1:RSA_DW-1] != {(AW-RSA_DW+1){sat_aw[AW-1]}});
    own = ovf_dw ? {sat_aw[AW-1], {(RSA_DW-1){~sat_aw[AW-1]}}} : sat_aw[RSA_DW-1:0];
    acc_upd = cal_en & ~cal_done & ~cfg_chg;
    acc_d = acc_upd ? sat_aw : '0;
    done_d = cal_done | (done_q & ~cal_en);
    ovf_d = cfg_chg ? 1'b0 : ((ovf_q & ~(cal_en & done_q)) | (acc_upd & ovf_aw) | (cal_done & (ovf_aw | ovf_dw)));
  end
  // Result arbitration: FIFO head first, then own result, then incoming; losers queue in that order
  always_comb begin
    res_in = dir_h ? res_W_i : res_E_i;
    head = mem_q[rp_q];
    head_v = (cnt_q != '0) & ~cfg_chg;
    own_v = cal_done;
    own_w = {1'b1, own};
    in_v = res_in[RW-1];
    sel = head_v ? head : own_v ? own_w : in_v ? res_in : '0;
    p0_v = ~cfg_chg & (head_v ? (own_v | in_v) : (own_v & in_v));
    p0 = (head_v & own_v) ? own_w : res_in;
    p1_v = ~cfg_chg & head_v & own_v & in_v;
    free = (FW+1)'(RES_DEPTH) - cnt_q + (FW+1)'(head_v);
    ok0 = p0_v & (free != '0);
    ok1 = p1_v & (free >= (FW+1)'(2));
    drop_d = drop_q | (p0_v & ~ok0) | (p1_v & ~ok1);
    wp1 = wp_q + FW'(1);
    mem_d = mem_q;
    if (ok0) mem_d[wp_q] = p0;
    if (ok1) mem_d[wp1] = res_in;
    wp_d = cfg_chg ? '0 : wp_q + FW'(ok0) + FW'(ok1);
    rp_d = cfg_chg ? '0 : rp_q + FW'(head_v);
    cnt_d = cfg_chg ? '0 : cnt_q - (FW+1)'(head_v) + (FW+1)'(ok0) + (FW+1)'(ok1);
    res_W_d = dir_h ? '0 : sel;
    res_E_d = dir_h ? sel : '0;
  end
  // State registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      {ctl_N_q, ctl_S_q, v_N_q, v_S_q, h_W_q, h_E_q} <= '0;
      {res_W_q, res_E_q, cfg_q, prod_q, acc_q} <= '0;
      {ovf_q, done_q, drop_q, wp_q, rp_q, cnt_q} <= '0;
      mem_q <= '{default: '0};
    end else begin
      {ctl_N_q, ctl_S_q, v_N_q, v_S_q, h_W_q, h_E_q} <= {ctl_N_d, ctl_S_d, v_N_d, v_S_d, h_W_d, h_E_d};
      {res_W_q, res_E_q, cfg_q, prod_q, acc_q} <= {res_W_d, res_E_d, cfg, prod_d, acc_d};
      {ovf_q, done_q, drop_q, wp_q, rp_q, cnt_q} <= {ovf_d, done_d, drop_d, wp_d, rp_d, cnt_d};
      mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_pe_mac_bidir.sv
// tb_pe_mac_bidir: scoreboard bench for pe_mac_bidir, saturating and wrapping instances in lockstep
module tb_pe_mac_bidir;
  localparam logic [15:0] JUNK = 16'h1357;
  localparam logic [16:0] RJ = {1'b1, 16'h0BAD};
  typedef struct packed {logic side; logic [15:0] d0; logic [15:0] d1;} exp_t;
  logic clk = 1'b0, sys_rst = 1'b1, dir_v = 1'b0, dir_h = 1'b0;
  logic [1:0] PE_mode = 2'b00, ctl_N_i = '0, ctl_S_i = '0;
  logic [15:0] v_N_i = '0, v_S_i = '0, h_W_i = '0, h_E_i = '0;
  logic [16:0] res_W_i = '0, res_E_i = '0;
  logic [1:0] ctl_N_o, ctl_S_o, ctl_N_o1, ctl_S_o1;
  logic [15:0] v_N_o, v_S_o, h_W_o, h_E_o, v_N_o1, v_S_o1, h_W_o1, h_E_o1;
  logic [16:0] res_W_o, res_E_o, res_W_o1, res_E_o1;
  logic ovf_o, drop_o, ovf_o1, drop_o1;
  int n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  pe_mac_bidir #(.SAT_EN(1)) dut (
    .clk(clk), .sys_rst(sys_rst), .PE_mode(PE_mode), .dir_v(dir_v), .dir_h(dir_h),
    .ctl_N_i(ctl_N_i), .ctl_S_i(ctl_S_i), .ctl_N_o(ctl_N_o), .ctl_S_o(ctl_S_o),
    .v_N_i(v_N_i), .v_S_i(v_S_i), .v_N_o(v_N_o), .v_S_o(v_S_o),
    .h_W_i(h_W_i), .h_E_i(h_E_i), .h_W_o(h_W_o), .h_E_o(h_E_o),
    .res_W_i(res_W_i), .res_E_i(res_E_i), .res_W_o(res_W_o), .res_E_o(res_E_o),
    .ovf_o(ovf_o), .drop_o(drop_o));
  pe_mac_bidir #(.SAT_EN(0)) dut_w (
    .clk(clk), .sys_rst(sys_rst), .PE_mode(PE_mode), .dir_v(dir_v), .dir_h(dir_h),
    .ctl_N_i(ctl_N_i), .ctl_S_i(ctl_S_i), .ctl_N_o(ctl_N_o1), .ctl_S_o(ctl_S_o1),
    .v_N_i(v_N_i), .v_S_i(v_S_i), .v_N_o(v_N_o1), .v_S_o(v_S_o1),
    .h_W_i(h_W_i), .h_E_i(h_E_i), .h_W_o(h_W_o1), .h_E_o(h_E_o1),
    .res_W_i(res_W_i), .res_E_i(res_E_i), .res_W_o(res_W_o1), .res_E_o(res_E_o1),
    .ovf_o(ovf_o1), .drop_o(drop_o1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_vh"}, {v_N_o, v_S_o, h_W_o, h_E_o}, 64'd0);
    check({nm, "_misc"}, {ctl_N_o, ctl_S_o, res_W_o, res_E_o, ovf_o, drop_o}, 64'd0);
    check({nm, "_vh_w"}, {v_N_o1, v_S_o1, h_W_o1, h_E_o1}, 64'd0);
    check({nm, "_misc_w"}, {ctl_N_o1, ctl_S_o1, res_W_o1, res_E_o1, ovf_o1, drop_o1}, 64'd0);
  endtask

  // side 0 = result leaves on res_W_o, side 1 = res_E_o; d0 for the saturating PE, d1 for the wrapping PE
  task automatic expect_res(input logic side, input logic [15:0] d0, input logic [15:0] d1);
    exp_q.push_back({side, d0, d1});
  endtask

  // one cycle of stimulus on the currently active sides, junk on the inactive ones
  task automatic drive(input logic [1:0] c, input logic [15:0] h, input logic [15:0] v, input logic [16:0] r);
    ctl_N_i = dir_v ? 2'b00 : c;
    ctl_S_i = dir_v ? c : 2'b00;
    v_N_i = dir_v ? JUNK : v;
    v_S_i = dir_v ? v : JUNK;
    h_W_i = dir_h ? JUNK : h;
    h_E_i = dir_h ? h : JUNK;
    res_E_i = dir_h ? RJ : r;
    res_W_i = dir_h ? r : RJ;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 16'd0, 16'd0, 17'd0);
  endtask

  // monitor: every valid result is popped against the scoreboard
  always @(negedge clk) begin
    if (res_W_o[16] | res_E_o[16] | res_W_o1[16] | res_E_o1[16]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL res_unexpected: got W=%h E=%h W1=%h E1=%h expected none", res_W_o, res_E_o, res_W_o1, res_E_o1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_sat", {res_W_o, res_E_o}, e.side ? {17'd0, 1'b1, e.d0} : {1'b1, e.d0, 17'd0});
        check("res_wrap", {res_W_o1, res_E_o1}, e.side ? {17'd0, 1'b1, e.d1} : {1'b1, e.d1, 17'd0});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    check_zero("reset");
    sys_rst = 1'b0;
    idle(2);
    // Q8 dot product, N->S and W->E
    drive(2'b01, 16'd512, 16'd768, 17'd0);
    check("fwd_act1", {v_S_o, h_E_o, ctl_S_o}, {16'd768, 16'd512, 2'b01});
    check("fwd_idle1", {v_N_o, h_W_o, ctl_N_o}, 64'd0);
    drive(2'b01, 16'd128, 16'd1024, 17'd0);
    check("fwd_act2", {v_S_o, h_E_o, ctl_S_o}, {16'd1024, 16'd128, 2'b01});
    expect_res(1'b0, 16'd2048, 16'd2048);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    check("lat_dot", {res_W_o, res_E_o, ovf_o}, {1'b1, 16'd2048, 17'd0, 1'b0});
    idle(2);
    // negative product and floor truncation, results travel W->E
    dir_h = 1'b1;
    idle(1);
    drive(2'b01, 16'hFE80, 16'd512, 17'd0);
    check("fwd_h_rev", {h_W_o, h_E_o}, {16'hFE80, 16'h0000});
    expect_res(1'b1, 16'hFD00, 16'hFD00);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    drive(2'b01, 16'hFFFF, 16'd1, 17'd0);
    expect_res(1'b1, 16'hFFFF, 16'hFFFF);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    check("ovf_neg", {ovf_o, ovf_o1}, 2'b00);
    dir_h = 1'b0;
    idle(2);
    // saturation vs wrap of the guard-clamped accumulator
    drive(2'b01, 16'd25600, 16'd25600, 17'd0);
    expect_res(1'b0, 16'd32767, 16'hFFFF);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    check("ovf_set", {ovf_o, ovf_o1}, 2'b11);
    idle(1);
    check("ovf_sticky", {ovf_o, ovf_o1}, 2'b11);
    drive(2'b01, 16'd256, 16'd256, 17'd0);
    check("ovf_clr", {ovf_o, ovf_o1}, 2'b00);
    expect_res(1'b0, 16'd256, 16'd256);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    idle(2);
    // own result collides with incoming result
    drive(2'b01, 16'd512, 16'd1024, 17'd0);
    expect_res(1'b0, 16'd2048, 16'd2048);
    expect_res(1'b0, 16'd5, 16'd5);
    drive(2'b10, 16'd0, 16'd0, {1'b1, 16'd5});
    idle(2);
    // back-to-back results plus incoming traffic until the FIFO overflows
    drive(2'b01, 16'd256, 16'd256, 17'd0);
    expect_res(1'b0, 16'd256, 16'd256);
    expect_res(1'b0, 16'h0011, 16'h0011);
    drive(2'b11, 16'd512, 16'd256, {1'b1, 16'h0011});
    expect_res(1'b0, 16'd512, 16'd512);
    expect_res(1'b0, 16'h0022, 16'h0022);
    drive(2'b11, 16'd768, 16'd256, {1'b1, 16'h0022});
    check("drop_pre", {drop_o, drop_o1}, 2'b00);
    expect_res(1'b0, 16'd768, 16'd768);
    drive(2'b10, 16'd0, 16'd0, {1'b1, 16'h0033});
    check("drop_set", {drop_o, drop_o1}, 2'b11);
    idle(3);
    // mode change mid-accumulation discards the first term
    drive(2'b01, 16'd256, 16'd256, 17'd0);
    PE_mode = 2'b01;
    drive(2'b01, 16'd512, 16'd512, 17'd0);
    drive(2'b01, 16'd256, 16'd768, 17'd0);
    expect_res(1'b0, 16'd1792, 16'd1792);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    idle(2);
    // vertical flip while a result is queued: queue flushed, N side takes over
    drive(2'b01, 16'd512, 16'd1024, 17'd0);
    expect_res(1'b0, 16'd2048, 16'd2048);
    drive(2'b10, 16'd0, 16'd0, {1'b1, 16'h0077});
    dir_v = 1'b1;
    drive(2'b01, 16'd256, 16'd768, 17'd0);
    check("flip_n_act", {v_N_o, h_E_o, ctl_N_o}, {16'd768, 16'd256, 2'b01});
    check("flip_s_idle", {v_S_o, ctl_S_o, h_W_o}, 64'd0);
    expect_res(1'b0, 16'd768, 16'd768);
    drive(2'b10, 16'd0, 16'd0, 17'd0);
    dir_v = 1'b0;
    idle(3);
    // reset one cycle before cal_done
    drive(2'b01, 16'd25600, 16'd25600, 17'd0);
    drive(2'b01, 16'd256, 16'd256, 17'd0);
    check("pre_rst_flags", {ovf_o, drop_o, ovf_o1, drop_o1}, 4'b1111);
    sys_rst = 1'b1;
    drive(2'b01, 16'd256, 16'd256, 17'd0);
    check_zero("mid_rst");
    sys_rst = 1'b0;
    idle(1);
    check_zero("post_rst");
    idle(3);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
